// File: rtl/rob_multiport.sv
`default_nettype none
// ============================================================================
// rob_multiport : multi-lane reorder buffer with in-order gated retirement
// Revision      : 1.0
// ============================================================================
module rob_multiport #(
   parameter int DEPTH   = 16,
   parameter int ALLOC_W = 2,
   parameter int CMT_W   = 4,
   parameter int RET_W   = 2,
   parameter int IW      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic [ALLOC_W-1:0]    alloc_valid_i,
   input  logic [ALLOC_W*2-1:0]  alloc_type_i,
   output logic                  alloc_ready_o,
   output logic [ALLOC_W*IW-1:0] alloc_idx_o,
   output logic [ALLOC_W-1:0]    alloc_pos_o,
   input  logic [CMT_W-1:0]      cmt_valid_i,
   input  logic [CMT_W*IW-1:0]   cmt_idx_i,
   input  logic [CMT_W-1:0]      cmt_exc_i,
   input  logic [CMT_W-1:0]      cmt_redirect_i,
   output logic [RET_W-1:0]      ret_valid_o,
   output logic [RET_W*IW-1:0]   ret_idx_o,
   output logic [RET_W*2-1:0]    ret_type_o,
   output logic [RET_W-1:0]      ret_exc_o,
   output logic [RET_W-1:0]      ret_redirect_o,
   output logic [IW:0]           count_o,
   output logic [IW-1:0]         oldest_idx_o
);

   localparam logic [1:0] TYPE_BRANCH = 2'b01;
   localparam logic [1:0] TYPE_STORE  = 2'b10;
   localparam logic [IW:0] READY_MAX  = (IW+1)'(DEPTH - ALLOC_W);

   logic [IW:0]              head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [DEPTH-1:0]         busy_q, busy_d, comp_q, comp_d;
   logic [DEPTH-1:0]         exc_q, exc_d, redir_q, redir_d;
   logic [DEPTH-1:0][1:0]    type_q, type_d;
   logic                     alloc_fire;
   logic [IW:0]              n_alloc, n_ret;

   assign alloc_ready_o = (count_q <= READY_MAX);
   assign alloc_fire    = alloc_ready_o && (|alloc_valid_i);
   assign count_o       = count_q;
   assign oldest_idx_o  = head_q[IW-1:0];

   generate
      for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc_lane
         logic [IW:0] lane_ptr;
         assign lane_ptr                  = tail_q + (IW+1)'(i);
         assign alloc_idx_o[i*IW +: IW]   = lane_ptr[IW-1:0];
         assign alloc_pos_o[i]            = lane_ptr[IW];
      end
   endgenerate

   // Retire lanes chain: each lane needs all older lanes retiring and no hazard among them.
   always_comb begin
      logic [IW-1:0] idx;
      logic          lane_ok, blocked, br_seen, st_seen;
      ret_valid_o    = '0;
      ret_idx_o      = '0;
      ret_type_o     = '0;
      ret_exc_o      = '0;
      ret_redirect_o = '0;
      idx            = '0;
      lane_ok        = 1'b1;
      blocked        = 1'b0;
      br_seen        = 1'b0;
      st_seen        = 1'b0;
      for (int j = 0; j < RET_W; j++) begin
         idx                        = head_q[IW-1:0] + IW'(j);
         ret_idx_o[j*IW +: IW]      = idx;
         ret_type_o[j*2 +: 2]       = type_q[idx];
         ret_exc_o[j]               = exc_q[idx];
         ret_redirect_o[j]          = redir_q[idx];
         lane_ok = lane_ok && ((IW+1)'(j) < count_q) && busy_q[idx] && comp_q[idx]
                   && !blocked
                   && !((type_q[idx] == TYPE_BRANCH) && br_seen)
                   && !((type_q[idx] == TYPE_STORE) && st_seen);
         ret_valid_o[j] = lane_ok;
         if (lane_ok) begin
            blocked = blocked | exc_q[idx] | redir_q[idx];
            br_seen = br_seen | (type_q[idx] == TYPE_BRANCH);
            st_seen = st_seen | (type_q[idx] == TYPE_STORE);
         end
      end
   end

   always_comb begin
      logic [IW-1:0] e;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      busy_d  = busy_q;
      comp_d  = comp_q;
      exc_d   = exc_q;
      redir_d = redir_q;
      type_d  = type_q;
      n_alloc = '0;
      n_ret   = '0;
      e       = '0;
      for (int j = 0; j < RET_W; j++)
         n_ret = n_ret + (IW+1)'(ret_valid_o[j]);
      if (alloc_fire)
         for (int i = 0; i < ALLOC_W; i++)
            n_alloc = n_alloc + (IW+1)'(alloc_valid_i[i]);

      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         busy_d  = '0;
         comp_d  = '0;
      end else begin
         // Ascending port order lets the highest port win on duplicate indices.
         for (int k = 0; k < CMT_W; k++) begin
            e = cmt_idx_i[k*IW +: IW];
            if (cmt_valid_i[k] && busy_q[e]) begin
               comp_d[e]  = 1'b1;
               exc_d[e]   = cmt_exc_i[k];
               redir_d[e] = cmt_redirect_i[k];
            end
         end
         for (int j = 0; j < RET_W; j++) begin
            if (ret_valid_o[j]) begin
               e         = ret_idx_o[j*IW +: IW];
               busy_d[e] = 1'b0;
               comp_d[e] = 1'b0;
            end
         end
         if (alloc_fire) begin
            for (int i = 0; i < ALLOC_W; i++) begin
               if (alloc_valid_i[i]) begin
                  e          = tail_q[IW-1:0] + IW'(i);
                  busy_d[e]  = 1'b1;
                  comp_d[e]  = 1'b0;
                  exc_d[e]   = 1'b0;
                  redir_d[e] = 1'b0;
                  type_d[e]  = alloc_type_i[i*2 +: 2];
               end
            end
         end
         head_d  = head_q + n_ret;
         tail_d  = tail_q + n_alloc;
         count_d = count_q + n_alloc - n_ret;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         comp_q  <= '0;
         exc_q   <= '0;
         redir_q <= '0;
         type_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         comp_q  <= comp_d;
         exc_q   <= exc_d;
         redir_q <= redir_d;
         type_q  <= type_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// ============================================================================
// tb_rob_multiport : directed vector bench for rob_multiport
// Revision         : 1.0
// ============================================================================
module tb_rob_multiport;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  alloc_valid_i = '0;
   logic [3:0]  alloc_type_i = '0;
   logic        alloc_ready_o;
   logic [7:0]  alloc_idx_o;
   logic [1:0]  alloc_pos_o;
   logic [3:0]  cmt_valid_i = '0;
   logic [15:0] cmt_idx_i = '0;
   logic [3:0]  cmt_exc_i = '0;
   logic [3:0]  cmt_redirect_i = '0;
   logic [1:0]  ret_valid_o;
   logic [7:0]  ret_idx_o;
   logic [3:0]  ret_type_o;
   logic [1:0]  ret_exc_o;
   logic [1:0]  ret_redirect_o;
   logic [4:0]  count_o;
   logic [3:0]  oldest_idx_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rob_multiport dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_i        (flush_i),
      .alloc_valid_i  (alloc_valid_i),
      .alloc_type_i   (alloc_type_i),
      .alloc_ready_o  (alloc_ready_o),
      .alloc_idx_o    (alloc_idx_o),
      .alloc_pos_o    (alloc_pos_o),
      .cmt_valid_i    (cmt_valid_i),
      .cmt_idx_i      (cmt_idx_i),
      .cmt_exc_i      (cmt_exc_i),
      .cmt_redirect_i (cmt_redirect_i),
      .ret_valid_o    (ret_valid_o),
      .ret_idx_o      (ret_idx_o),
      .ret_type_o     (ret_type_o),
      .ret_exc_o      (ret_exc_o),
      .ret_redirect_o (ret_redirect_o),
      .count_o        (count_o),
      .oldest_idx_o   (oldest_idx_o)
   );

   // One record per cycle: inputs driven that cycle, expected outputs before the edge.
   typedef struct {
      logic [1:0]  av;
      logic [3:0]  at;
      logic [3:0]  cv;
      logic [15:0] ci;
      logic [3:0]  ce;
      logic [3:0]  cr;
      logic        fl;
      logic [4:0]  e_count;
      logic        e_ready;
      logic [1:0]  e_ret;
      logic [3:0]  e_old;
      logic [3:0]  e_aidx;
      logic        e_pos;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(logic [1:0] av, logic [3:0] at, logic [3:0] cv, logic [15:0] ci,
                               logic [3:0] ce, logic [3:0] cr, logic fl, logic [4:0] ec,
                               logic er, logic [1:0] eret, logic [3:0] eold,
                               logic [3:0] eaidx, logic epos);
      vec_t v;
      v.av = av; v.at = at; v.cv = cv; v.ci = ci; v.ce = ce; v.cr = cr; v.fl = fl;
      v.e_count = ec; v.e_ready = er; v.e_ret = eret; v.e_old = eold;
      v.e_aidx = eaidx; v.e_pos = epos;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      alloc_valid_i  = v.av;
      alloc_type_i   = v.at;
      cmt_valid_i    = v.cv;
      cmt_idx_i      = v.ci;
      cmt_exc_i      = v.ce;
      cmt_redirect_i = v.cr;
      flush_i        = v.fl;
      #1;
      chk({tag, ".count"},  32'(count_o),       32'(v.e_count));
      chk({tag, ".ready"},  32'(alloc_ready_o), 32'(v.e_ready));
      chk({tag, ".ret"},    32'(ret_valid_o),   32'(v.e_ret));
      chk({tag, ".oldest"}, 32'(oldest_idx_o),  32'(v.e_old));
      chk({tag, ".aidx0"},  32'(alloc_idx_o[3:0]), 32'(v.e_aidx));
      chk({tag, ".pos0"},   32'(alloc_pos_o[0]),   32'(v.e_pos));
   endtask

   initial begin
      // Fill 16 entries two per cycle, complete 0..3, then retire two per cycle.
      for (int c = 0; c < 8; c++)
         tbl[c] = mk(2'b11, 4'b0000, 4'h0, 16'h0, 4'h0, 4'h0, 1'b0,
                     5'(2*c), 1'b1, 2'b00, 4'd0, 4'(2*c), 1'b0);
      tbl[8]  = mk(2'b00, 4'b0000, 4'hF, 16'h3210, 4'h0, 4'h0, 1'b0, 5'd16, 1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
      tbl[9]  = mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd16, 1'b0, 2'b11, 4'd0, 4'd0, 1'b1);
      tbl[10] = mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd14, 1'b1, 2'b11, 4'd2, 4'd0, 1'b1);
      tbl[11] = mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd14, 1'b1, 2'b00, 4'd4, 4'd2, 1'b1);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 12; c++)
         apply($sformatf("tbl%0d", c), tbl[c]);

      // Asynchronous reset in the middle of operation
      @(negedge clk);
      alloc_valid_i = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("arst.count", 32'(count_o), 32'd0);
      chk("arst.ready", 32'(alloc_ready_o), 32'd1);
      chk("arst.ret",   32'(ret_valid_o), 32'd0);
      chk("arst.aidx1", 32'(alloc_idx_o[7:4]), 32'd1);
      #2;
      rst_n = 1'b1;

      // Two branches: only one branch retires per cycle
      apply("br.a", mk(2'b11, 4'b0101, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd0, 4'd0, 1'b0));
      apply("br.b", mk(2'b00, 4'b0000, 4'h3, 16'h0010, 4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b00, 4'd0, 4'd2, 1'b0));
      apply("br.c", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b01, 4'd0, 4'd2, 1'b0));
      chk("br.c.idx0",  32'(ret_idx_o[3:0]),  32'd0);
      chk("br.c.type0", 32'(ret_type_o[1:0]), 32'd1);
      apply("br.d", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd1, 1'b1, 2'b01, 4'd1, 4'd2, 1'b0));
      chk("br.d.idx0",  32'(ret_idx_o[3:0]),  32'd1);

      // Exception on older entry, duplicate commit to entry 3 (port 3 wins, no redirect)
      apply("exc.a", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd2, 4'd2, 1'b0));
      apply("exc.b", mk(2'b00, 4'b0000, 4'hF, 16'h3332, 4'h1, 4'h4, 1'b0, 5'd2, 1'b1, 2'b00, 4'd2, 4'd4, 1'b0));
      apply("exc.c", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b01, 4'd2, 4'd4, 1'b0));
      chk("exc.c.exc0",  32'(ret_exc_o[0]),      32'd1);
      chk("exc.c.idx0",  32'(ret_idx_o[3:0]),    32'd2);
      chk("exc.c.redir1", 32'(ret_redirect_o[1]), 32'd0);
      apply("exc.d", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd1, 1'b1, 2'b01, 4'd3, 4'd4, 1'b0));
      chk("exc.d.exc0",  32'(ret_exc_o[0]),     32'd0);
      chk("exc.d.redir0", 32'(ret_redirect_o[0]), 32'd0);

      // Redirect on older entry holds the younger one back a cycle
      apply("rd.a", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd4, 4'd4, 1'b0));
      apply("rd.b", mk(2'b00, 4'b0000, 4'h3, 16'h0054, 4'h0, 4'h1, 1'b0, 5'd2, 1'b1, 2'b00, 4'd4, 4'd6, 1'b0));
      apply("rd.c", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b01, 4'd4, 4'd6, 1'b0));
      chk("rd.c.redir0", 32'(ret_redirect_o[0]), 32'd1);
      apply("rd.d", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd1, 1'b1, 2'b01, 4'd5, 4'd6, 1'b0));

      // Two stores: only one store retires per cycle
      apply("st.a", mk(2'b11, 4'b1010, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd6, 4'd6, 1'b0));
      apply("st.b", mk(2'b00, 4'b0000, 4'h3, 16'h0076, 4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b00, 4'd6, 4'd8, 1'b0));
      apply("st.c", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b01, 4'd6, 4'd8, 1'b0));
      chk("st.c.type0", 32'(ret_type_o[1:0]), 32'd2);
      apply("st.d", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd1, 1'b1, 2'b01, 4'd7, 4'd8, 1'b0));

      // Build count 7 with entry 8 complete, then flush alongside an alloc request
      apply("fl.a", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd8, 4'd8,  1'b0));
      apply("fl.b", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b00, 4'd8, 4'd10, 1'b0));
      apply("fl.c", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd4, 1'b1, 2'b00, 4'd8, 4'd12, 1'b0));
      apply("fl.d", mk(2'b01, 4'b0000, 4'h1, 16'h0008, 4'h0, 4'h0, 1'b0, 5'd6, 1'b1, 2'b00, 4'd8, 4'd14, 1'b0));
      apply("fl.e", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b1, 5'd7, 1'b1, 2'b01, 4'd8, 4'd15, 1'b0));
      apply("fl.f", mk(2'b11, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 4'd0, 4'd0,  1'b0));
      apply("fl.g", mk(2'b00, 4'b0000, 4'h0, 16'h0,    4'h0, 4'h0, 1'b0, 5'd2, 1'b1, 2'b00, 4'd0, 4'd2,  1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
